// File: rtl/imem_dmem_arbiter.sv
// rtl/imem_dmem_arbiter.sv - single-port RAM arbiter between fetch and memory stage
module imem_dmem_arbiter #(
  parameter int ADDR_W       = 16,
  parameter int DATA_W       = 16,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_stall,
  output logic              if_valid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              dm_req,
  input  logic              dm_wr,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic              dm_stall,
  output logic              dm_valid,
  output logic [DATA_W-1:0] dm_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_data,
  output logic              mem_wren,
  input  logic [DATA_W-1:0] mem_q
);

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    IF_RD = 2'd1,
    DM_RD = 2'd2,
    DM_WR = 2'd3
  } state_t;

  state_t            state;
  state_t            next_state;
  logic [3:0]        starve_cnt;
  logic [DATA_W-1:0] if_hold;
  logic [DATA_W-1:0] dm_hold;
  logic              gnt_dm;
  logic              gnt_if;

  // Grant: data wins unless fetch has waited through STARVE_LIMIT data grants.
  always_comb begin
    gnt_dm   = dm_req & (~if_req | (starve_cnt < LIMIT));
    gnt_if   = if_req & ~gnt_dm;
    if_stall = if_req & ~gnt_if;
    dm_stall = dm_req & ~gnt_dm;
  end

  // RAM port steering; write data is forced to zero on any non-write cycle.
  always_comb begin
    mem_addr = '0;
    mem_data = '0;
    mem_wren = 1'b0;
    if (gnt_dm) begin
      mem_addr = dm_addr;
      mem_wren = dm_wr;
      if (dm_wr) begin
        mem_data = dm_wdata;
      end
    end else if (gnt_if) begin
      mem_addr = if_addr;
    end
  end

  // Owner FSM register: remembers which access the RAM is answering this cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Owner FSM next state and return-path outputs.
  always_comb begin
    next_state = IDLE;
    if (gnt_dm && dm_wr) begin
      next_state = DM_WR;
    end else if (gnt_dm) begin
      next_state = DM_RD;
    end else if (gnt_if) begin
      next_state = IF_RD;
    end
    if_valid = (state == IF_RD);
    dm_valid = (state == DM_RD) || (state == DM_WR);
    if_rdata = (state == IF_RD) ? mem_q : if_hold;
    dm_rdata = (state == DM_RD) ? mem_q : dm_hold;
  end

  // Starvation counter: counts data grants taken while fetch is waiting.
  always_ff @(posedge clk) begin
    if (rst) begin
      starve_cnt <= 4'd0;
    end else if (gnt_if || !if_req) begin
      starve_cnt <= 4'd0;
    end else if (gnt_dm && (starve_cnt < LIMIT)) begin
      starve_cnt <= starve_cnt + 4'd1;
    end
  end

  // Hold registers keep the last delivered read so outputs are stable between reads.
  always_ff @(posedge clk) begin
    if (rst) begin
      if_hold <= '0;
      dm_hold <= '0;
    end else begin
      if (state == IF_RD) begin
        if_hold <= mem_q;
      end
      if (state == DM_RD) begin
        dm_hold <= mem_q;
      end
    end
  end

endmodule

// File: tb/tb_imem_dmem_arbiter.sv
// tb/tb_imem_dmem_arbiter.sv - self-checking bench for imem_dmem_arbiter
module tb_imem_dmem_arbiter;

  localparam int LIMIT = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req;
  logic [15:0] if_addr;
  logic        if_stall;
  logic        if_valid;
  logic [15:0] if_rdata;
  logic        dm_req;
  logic        dm_wr;
  logic [15:0] dm_addr;
  logic [15:0] dm_wdata;
  logic        dm_stall;
  logic        dm_valid;
  logic [15:0] dm_rdata;
  logic [15:0] mem_addr;
  logic [15:0] mem_data;
  logic        mem_wren;
  logic [15:0] mem_q;

  logic [15:0] ram     [0:65535];
  logic [15:0] ref_mem [0:65535];

  int tests = 0;
  int fails = 0;

  // reference model state
  bit          m_if_pend = 0;
  logic [15:0] m_if_pdata = 16'h0;
  bit          m_dm_pend = 0;
  bit          m_dm_load = 0;
  logic [15:0] m_dm_pdata = 16'h0;
  logic [15:0] m_if_hold = 16'h0;
  logic [15:0] m_dm_hold = 16'h0;
  int          m_streak = 0;

  imem_dmem_arbiter #(.ADDR_W(16), .DATA_W(16), .STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_stall(if_stall),
    .if_valid(if_valid), .if_rdata(if_rdata),
    .dm_req(dm_req), .dm_wr(dm_wr), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_stall(dm_stall), .dm_valid(dm_valid), .dm_rdata(dm_rdata),
    .mem_addr(mem_addr), .mem_data(mem_data), .mem_wren(mem_wren),
    .mem_q(mem_q)
  );

  always #5 clk = ~clk;

  // single-port synchronous RAM, read-before-write
  always @(posedge clk) begin
    if (mem_wren) ram[mem_addr] <= mem_data;
    mem_q <= ram[mem_addr];
  end

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic step(input logic r, input logic iq, input logic [15:0] ia,
                      input logic dq, input logic dw, input logic [15:0] da,
                      input logic [15:0] dwd, input bit chk_ret);
    bit          g_dm, g_if;
    logic [15:0] e_addr, e_data;
    rst = r; if_req = iq; if_addr = ia;
    dm_req = dq; dm_wr = dw; dm_addr = da; dm_wdata = dwd;
    #1;
    g_dm   = dq && (!iq || m_streak < LIMIT);
    g_if   = iq && !g_dm;
    e_addr = g_dm ? da : (g_if ? ia : 16'h0);
    e_data = (g_dm && dw) ? dwd : 16'h0;
    chk("if_stall", {15'h0, if_stall}, {15'h0, iq && !g_if});
    chk("dm_stall", {15'h0, dm_stall}, {15'h0, dq && !g_dm});
    chk("mem_addr", mem_addr, e_addr);
    chk("mem_data", mem_data, e_data);
    chk("mem_wren", {15'h0, mem_wren}, {15'h0, g_dm && dw});
    if (chk_ret) begin
      chk("if_valid", {15'h0, if_valid}, {15'h0, m_if_pend});
      chk("dm_valid", {15'h0, dm_valid}, {15'h0, m_dm_pend});
      chk("if_rdata", if_rdata, m_if_pend ? m_if_pdata : m_if_hold);
      chk("dm_rdata", dm_rdata, (m_dm_pend && m_dm_load) ? m_dm_pdata : m_dm_hold);
    end
    @(posedge clk);
    if (r) begin
      m_if_hold = 16'h0;
      m_dm_hold = 16'h0;
      m_if_pend = 0;
      m_dm_pend = 0;
      m_streak  = 0;
    end else begin
      if (m_if_pend) m_if_hold = m_if_pdata;
      if (m_dm_pend && m_dm_load) m_dm_hold = m_dm_pdata;
      m_if_pend  = g_if;
      m_if_pdata = ref_mem[ia];
      m_dm_pend  = g_dm;
      m_dm_load  = !dw;
      m_dm_pdata = ref_mem[da];
      if (g_if || !iq) m_streak = 0;
      else if (g_dm && m_streak < LIMIT) m_streak = m_streak + 1;
    end
    if (g_dm && dw) ref_mem[da] = dwd;
    @(negedge clk);
  endtask

  initial begin
    for (int i = 0; i < 65536; i++) begin
      ram[i]     = 16'($urandom);
      ref_mem[i] = ram[i];
    end
    @(negedge clk);
    // reset
    step(1, 0, 16'h0, 0, 0, 16'h0, 16'h0, 0);
    step(1, 0, 16'h0, 0, 0, 16'h0, 16'h0, 1);
    step(0, 0, 16'h0, 0, 0, 16'h0, 16'h0, 1);
    // sequential fetch
    step(0, 1, 16'h0000, 0, 0, 16'h0, 16'h0, 1);
    step(0, 1, 16'h0001, 0, 0, 16'h0, 16'h0, 1);
    step(0, 1, 16'h0002, 0, 0, 16'h0, 16'h0, 1);
    step(0, 0, 16'h0, 0, 0, 16'h0, 16'h0, 1);
    // store with fetch pending, then load back
    step(0, 1, 16'h0003, 1, 1, 16'h0010, 16'hBEEF, 1);
    step(0, 1, 16'h0003, 0, 0, 16'h0, 16'h0, 1);
    step(0, 0, 16'h0, 1, 0, 16'h0010, 16'h0, 1);
    step(0, 0, 16'h0, 0, 0, 16'h0, 16'h0, 1);
    chk("load_beef", dm_rdata, 16'hBEEF);
    // starvation: loads and fetch both held 10 cycles
    for (int i = 0; i < 10; i++) step(0, 1, 16'h0020, 1, 0, 16'(16'h0040 + i), 16'h0, 1);
    step(0, 0, 16'h0, 0, 0, 16'h0, 16'h0, 1);
    // fetch 0x1234, then fetch stalled behind a load holds it
    step(0, 0, 16'h0, 1, 1, 16'h0030, 16'h1234, 1);
    step(0, 1, 16'h0030, 0, 0, 16'h0, 16'h0, 1);
    step(0, 1, 16'h0031, 1, 0, 16'h0010, 16'h0, 1);
    chk("if_hold_1234", if_rdata, 16'h1234);
    step(0, 1, 16'h0031, 0, 0, 16'h0, 16'h0, 1);
    step(0, 0, 16'h0, 0, 0, 16'h0, 16'h0, 1);
    // load granted while reset asserted
    step(1, 0, 16'h0, 1, 0, 16'h0010, 16'h0, 1);
    step(0, 0, 16'h0, 0, 0, 16'h0, 16'h0, 1);
    // address wrap
    step(0, 1, 16'hFFFF, 0, 0, 16'h0, 16'h0, 1);
    step(0, 1, 16'h0000, 0, 0, 16'h0, 16'h0, 1);
    step(0, 0, 16'h0, 0, 0, 16'h0, 16'h0, 1);
    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      logic [15:0] ia, da;
      ia = ($urandom_range(0, 15) == 0) ? 16'hFFFF : 16'($urandom_range(0, 31));
      da = ($urandom_range(0, 15) == 0) ? 16'hFFFF : 16'($urandom_range(0, 31));
      step($urandom_range(0, 39) == 0, $urandom_range(0, 3) != 0, ia,
           $urandom_range(0, 3) != 0, 1'($urandom), da, 16'($urandom), 1);
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/imem_dmem_arbiter.md
Name: imem_dmem_arbiter

Overview:
- Shares the single-port synchronous RAM between two requesters: the fetch stage (instruction reads) and the memory stage (data loads and stores).
- Grants at most one access per cycle and steers returned read data back to the owner.
- Generates stall signals to the losing requester.
- Data has priority; a starvation limit guarantees fetch forward progress.

Parameters:
- ADDR_W, 16, address width of both requesters and of the RAM.
- DATA_W, 16, data/instruction word width.
- STARVE_LIMIT, 4, maximum consecutive data grants while fetch is waiting; range 1..15.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- if_req  in  1  fetch wants an instruction read this cycle.
- if_addr  in  ADDR_W  fetch address (PC).
- if_stall  out  1  fetch request not granted this cycle; fetch must hold PC.
- if_valid  out  1  instruction on if_rdata is from the read granted last cycle.
- if_rdata  out  DATA_W  instruction word; holds the last delivered value when if_valid=0.
- dm_req  in  1  memory stage wants an access this cycle.
- dm_wr  in  1  1=store, 0=load; qualified by dm_req.
- dm_addr  in  ADDR_W  data address.
- dm_wdata  in  DATA_W  store data.
- dm_stall  out  1  data request not granted this cycle.
- dm_valid  out  1  completion of the data access granted last cycle (load or store).
- dm_rdata  out  DATA_W  load data; holds the last load value when no load completes.
- mem_addr  out  ADDR_W  RAM address.
- mem_data  out  DATA_W  RAM write data.
- mem_wren  out  1  RAM write enable.
- mem_q  in  DATA_W  RAM read data; valid one cycle after the address is presented.

Behaviour:
Grant (combinational, same cycle):
- gnt_dm = dm_req & (~if_req | starve_cnt < STARVE_LIMIT).
- gnt_if = if_req & ~gnt_dm.
- if_stall = if_req & ~gnt_if.
- dm_stall = dm_req & ~gnt_dm.

RAM drive (combinational):
- gnt_dm: mem_addr=dm_addr, mem_data=dm_wdata, mem_wren=dm_wr.
- gnt_if: mem_addr=if_addr, mem_wren=0.
- No grant: mem_addr=0, mem_data=0, mem_wren=0.
- mem_data=0 for all non-write cycles.

Owner FSM (registered; records the access granted in the previous cycle):
- States: IDLE, IF_RD, DM_RD, DM_WR.
- Next state = DM_WR if gnt_dm&dm_wr; DM_RD if gnt_dm&~dm_wr; IF_RD if gnt_if; else IDLE.
- Every state may transition to any state every cycle, so back-to-back grants sustain full throughput.

Return path:
- if_valid = (state==IF_RD).
- dm_valid = (state==DM_RD | state==DM_WR).
- if_rdata = if_valid ? mem_q : if_hold. if_hold loads mem_q at each edge where if_valid=1.
- dm_rdata = (state==DM_RD) ? mem_q : dm_hold. dm_hold loads mem_q at each edge where state==DM_RD.
- Stores never modify dm_hold.
- Latency: grant in cycle N gives valid in cycle N+1.

Starvation counter (starve_cnt, 4 bits):
- Clears to 0 when gnt_if=1 or if_req=0.
- Else increments, saturating at STARVE_LIMIT, when gnt_dm=1 and if_req=1.
- When starve_cnt==STARVE_LIMIT and both requesters are active, fetch wins; the counter clears and data stalls one cycle.

Reset (rst=1 at an edge):
- state=IDLE, starve_cnt=0, if_hold=0, dm_hold=0.
- Outputs in the following cycle: if_valid=0, dm_valid=0, if_rdata=0, dm_rdata=0.
- Grant and stall outputs remain combinational functions of the requests during reset.
- An access granted in the cycle rst is sampled produces no valid.

Boundary conditions:
- Both requests while starve_cnt<LIMIT: data wins, if_stall=1.
- Request toggled off while stalled: no grant and no valid; nothing is queued.
- Address wrap 0xFFFF: passed through unchanged; the arbiter performs no arithmetic on addresses.

Test Plan:
1. Reset, then if_req=1 only, if_addr=0x0000,0x0001,0x0002 on consecutive cycles -> mem_addr follows, if_stall=0, if_valid=1 from cycle 2, if_rdata = RAM[0],[1],[2] one cycle late.
2. Store dm_addr=0x0010, dm_wdata=0xBEEF with if_req=1 -> mem_wren=1, if_stall=1 that cycle, dm_valid=1 next cycle, dm_rdata unchanged; a later load of 0x0010 returns 0xBEEF.
3. dm_req=1 (loads) and if_req=1 held 10 cycles, STARVE_LIMIT=4 -> grant pattern D,D,D,D,I repeating; if_valid on cycles 6 and 11; dm_stall=1 on cycles 5 and 10.
4. Fetch stalled behind a load, if_rdata previously 0x1234 -> if_rdata stays 0x1234 with if_valid=0 until the fetch is granted.
5. Load granted, rst asserted the same cycle -> no dm_valid next cycle, dm_rdata=0, state IDLE, starve_cnt=0.
6. if_addr=0xFFFF granted, then 0x0000 -> both reads delivered in order with correct RAM data, no spurious stall.
